// File: rtl/epRISC_busPkg.sv
// Shared types and defaults for the front-side-bus arbiter.
// Holds the FSM states, requester IDs and default starvation/timeout limits.
package epRISC_busPkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } bus_state_t;

    localparam logic REQ_CORE = 1'b0;
    localparam logic REQ_DMA  = 1'b1;

    localparam int DEF_STARVE_LIMIT = 4;
    localparam int DEF_TIMEOUT      = 255;

    // IDLE and DONE are the only states in which a new owner may be picked.
    function automatic logic is_arb_state(input bus_state_t s);
        return (s == ST_IDLE) || (s == ST_DONE);
    endfunction

endpackage

// File: rtl/epRISC_busWatchdog.sv
// Clearable 8-bit ready-timeout counter; oExpired is a pure decode of the count register,
// so it flags the cycle in which TIMEOUT enabled cycles have already elapsed since iClear.
module epRISC_busWatchdog
    import epRISC_busPkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic iClock,
    input  logic iReset,
    input  logic iClear,
    input  logic iEnable,
    output logic oExpired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] r_count;

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_count <= 8'd0;
        end else if (iClear) begin
            r_count <= 8'd0;
        end else if (iEnable && (r_count != 8'hFF)) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign oExpired = (r_count == LIMIT);

endmodule

// File: rtl/eprisc_busarbiter.sv
// Two-master FSB arbiter: core has fixed priority, DMA wins after STARVE_LIMIT losses.
// One registered transfer at a time; completes on iBusReady or after TIMEOUT+1 ACCESS cycles.
module eprisc_busarbiter
    import epRISC_busPkg::*;
#(
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT,
    parameter int TIMEOUT      = DEF_TIMEOUT
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iReq0,
    input  logic        iReq1,
    input  logic [31:0] iAddr0,
    input  logic [31:0] iAddr1,
    input  logic        iWrite0,
    input  logic        iWrite1,
    input  logic [31:0] iWData0,
    input  logic [31:0] iWData1,
    output logic        oGrant0,
    output logic        oGrant1,
    output logic        oDone0,
    output logic        oDone1,
    output logic [31:0] oRData,
    output logic        oError,
    output logic [31:0] oBusAddress,
    output logic [31:0] oBusWData,
    output logic        oBusWrite,
    output logic        oBusAccess,
    input  logic        iBusReady,
    input  logic [31:0] iBusRData
);

    localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

    bus_state_t     r_state;
    bus_state_t     w_next;
    logic           r_owner;
    logic [SW-1:0]  r_starve;
    logic [31:0]    r_busAddr;
    logic [31:0]    r_busWData;
    logic           r_busWrite;
    logic [31:0]    r_rdata;
    logic           r_error;

    logic w_arb;
    logic w_starved;
    logic w_win;
    logic w_win1;
    logic w_expired;
    logic w_inAccess;
    logic w_access;
    logic w_grant0;
    logic w_grant1;
    logic w_done0;
    logic w_done1;

    assign w_arb      = is_arb_state(r_state);
    assign w_inAccess = (r_state == ST_ACCESS);
    assign w_starved  = (r_starve >= SW'(STARVE_LIMIT));
    assign w_win1     = iReq1 & (w_starved | ~iReq0);
    assign w_win      = w_arb & (iReq0 | iReq1);

    epRISC_busWatchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .iClock   (iClock),
        .iReset   (iReset),
        .iClear   (w_win),
        .iEnable  (w_inAccess),
        .oExpired (w_expired)
    );

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (iReq0 || iReq1) w_next = ST_ACCESS;
            ST_ACCESS: if (iBusReady || w_expired) w_next = ST_DONE;
            ST_DONE:   w_next = (iReq0 || iReq1) ? ST_ACCESS : ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_access = 1'b0;
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        w_done0  = 1'b0;
        w_done1  = 1'b0;
        case (r_state)
            ST_ACCESS: begin
                w_access = 1'b1;
                w_grant0 = (r_owner == REQ_CORE);
                w_grant1 = (r_owner == REQ_DMA);
            end
            ST_DONE: begin
                w_done0 = (r_owner == REQ_CORE);
                w_done1 = (r_owner == REQ_DMA);
            end
            default: ;
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            r_owner    <= REQ_CORE;
            r_starve   <= '0;
            r_busAddr  <= 32'd0;
            r_busWData <= 32'd0;
            r_busWrite <= 1'b0;
            r_rdata    <= 32'd0;
            r_error    <= 1'b0;
        end else begin
            // A DMA loss only happens below the limit, so the increment cannot overflow.
            if (w_arb) begin
                if (!iReq1 || w_win1) begin
                    r_starve <= '0;
                end else begin
                    r_starve <= r_starve + SW'(1);
                end
            end
            if (w_win) begin
                r_owner    <= w_win1 ? REQ_DMA : REQ_CORE;
                r_busAddr  <= w_win1 ? iAddr1  : iAddr0;
                r_busWData <= w_win1 ? iWData1 : iWData0;
                r_busWrite <= w_win1 ? iWrite1 : iWrite0;
            end
            // Ready is checked first so a coincident expiry still completes cleanly.
            if (w_inAccess) begin
                if (iBusReady) begin
                    r_rdata <= r_busWrite ? 32'd0 : iBusRData;
                    r_error <= 1'b0;
                end else if (w_expired) begin
                    r_rdata <= 32'd0;
                    r_error <= 1'b1;
                end
            end
        end
    end

    assign oGrant0     = w_grant0;
    assign oGrant1     = w_grant1;
    assign oDone0      = w_done0;
    assign oDone1      = w_done1;
    assign oBusAccess  = w_access;
    assign oBusWrite   = r_busWrite & w_access;
    assign oBusAddress = r_busAddr;
    assign oBusWData   = r_busWData;
    assign oRData      = r_rdata;
    assign oError      = r_error;

endmodule

// File: tb/tb_eprisc_busarbiter.sv
// Bench for eprisc_busarbiter: transaction-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_eprisc_busarbiter;

    localparam int TB_STARVE  = 4;
    localparam int TB_TIMEOUT = 255;

    logic        iClock = 1'b0;
    logic        iReset;
    logic        iReq0, iReq1;
    logic [31:0] iAddr0, iAddr1;
    logic        iWrite0, iWrite1;
    logic [31:0] iWData0, iWData1;
    logic        oGrant0, oGrant1, oDone0, oDone1;
    logic [31:0] oRData;
    logic        oError;
    logic [31:0] oBusAddress, oBusWData;
    logic        oBusWrite, oBusAccess;
    logic        iBusReady;
    logic [31:0] iBusRData;

    always #5 iClock = ~iClock;

    eprisc_busarbiter #(
        .STARVE_LIMIT (TB_STARVE),
        .TIMEOUT      (TB_TIMEOUT)
    ) dut (
        .iClock      (iClock),
        .iReset      (iReset),
        .iReq0       (iReq0),
        .iReq1       (iReq1),
        .iAddr0      (iAddr0),
        .iAddr1      (iAddr1),
        .iWrite0     (iWrite0),
        .iWrite1     (iWrite1),
        .iWData0     (iWData0),
        .iWData1     (iWData1),
        .oGrant0     (oGrant0),
        .oGrant1     (oGrant1),
        .oDone0      (oDone0),
        .oDone1      (oDone1),
        .oRData      (oRData),
        .oError      (oError),
        .oBusAddress (oBusAddress),
        .oBusWData   (oBusWData),
        .oBusWrite   (oBusWrite),
        .oBusAccess  (oBusAccess),
        .iBusReady   (iBusReady),
        .iBusRData   (iBusRData)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: who owns the bus, how long it has been waiting, who just finished.
    int          m_owner = -1;
    int          m_done  = -1;
    int          m_cyc   = 0;
    int          m_starve = 0;
    bit          m_inrst = 1'b0;
    bit          chk_en  = 1'b0;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_wr, e_err;

    always @(posedge iClock) begin : model
        int win;
        m_inrst = 1'b0;
        if (iReset) begin
            m_owner = -1; m_done = -1; m_cyc = 0; m_starve = 0;
            e_addr = 0; e_wdata = 0; e_wr = 0; e_rdata = 0; e_err = 0;
            m_inrst = 1'b1;
            chk_en  = 1'b1;
        end else if (m_owner >= 0) begin
            m_cyc = m_cyc + 1;
            if (iBusReady) begin
                m_done = m_owner; m_owner = -1;
                e_err = 1'b0; e_rdata = e_wr ? 32'd0 : iBusRData;
            end else if (m_cyc == TB_TIMEOUT + 1) begin
                m_done = m_owner; m_owner = -1;
                e_err = 1'b1; e_rdata = 32'd0;
            end
        end else begin
            m_done = -1;
            win = -1;
            if (iReq1 && m_starve >= TB_STARVE) win = 1;
            else if (iReq0) win = 0;
            else if (iReq1) win = 1;
            if (win == 0 && iReq1) m_starve = (m_starve < TB_STARVE) ? m_starve + 1 : TB_STARVE;
            else m_starve = 0;
            if (win >= 0) begin
                m_owner = win; m_cyc = 0;
                e_addr  = (win == 1) ? iAddr1  : iAddr0;
                e_wdata = (win == 1) ? iWData1 : iWData0;
                e_wr    = (win == 1) ? iWrite1 : iWrite0;
            end
        end
    end

    always @(negedge iClock) begin
        if (chk_en) begin
            chk("busAccess", oBusAccess, m_owner >= 0);
            chk("grant0", oGrant0, m_owner == 0);
            chk("grant1", oGrant1, m_owner == 1);
            chk("done0", oDone0, m_done == 0);
            chk("done1", oDone1, m_done == 1);
            chk("busAddress", oBusAddress, e_addr);
            chk("busWData", oBusWData, e_wdata);
            chk("busWrite", oBusWrite, e_wr && (m_owner >= 0));
            if (m_done >= 0 || m_inrst) begin
                chk("rData", oRData, e_rdata);
                chk("error", oError, e_err);
            end
        end
    end

    // Runs one transfer for requester id; ready is raised in ACCESS cycle rdy_at (0 = never).
    task automatic xfer(input int id, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wd, input int rdy_at, input logic [31:0] rd,
                        output int acc_n, output logic [31:0] got_rd, output logic got_err);
        logic got_done;
        acc_n = 0; got_done = 1'b0; got_rd = 32'd0; got_err = 1'b0;
        iBusRData = rd;
        if (id == 1) begin
            iReq1 = 1'b1; iAddr1 = addr; iWrite1 = wr; iWData1 = wd;
        end else begin
            iReq0 = 1'b1; iAddr0 = addr; iWrite0 = wr; iWData0 = wd;
        end
        for (int c = 0; c < 600 && !got_done; c++) begin
            @(posedge iClock); #2;
            if ((id == 1) ? oGrant1 : oGrant0) begin
                acc_n++;
                chk("xfer_addr_stable", oBusAddress, addr);
                chk("xfer_wdata_stable", oBusWData, wd);
                chk("xfer_write_stable", oBusWrite, wr);
                iBusReady = (acc_n == rdy_at);
            end else begin
                iBusReady = 1'b0;
            end
            if ((id == 1) ? oDone1 : oDone0) begin
                got_done = 1'b1;
                got_rd   = oRData;
                got_err  = oError;
                if (id == 1) iReq1 = 1'b0; else iReq0 = 1'b0;
            end
        end
        iBusReady = 1'b0;
        chk("xfer_done_seen", got_done, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [31:0] rd;
        logic        er;
        logic        seen;
        logic [9:0]  exp_order;
        logic [9:0]  got_order;

        iReset = 1'b1;
        iReq0 = 0; iReq1 = 0; iAddr0 = 0; iAddr1 = 0; iWrite0 = 0; iWrite1 = 0;
        iWData0 = 0; iWData1 = 0; iBusReady = 0; iBusRData = 0;
        repeat (2) @(posedge iClock);
        #2;
        chk("reset_busAccess", oBusAccess, 1'b0);
        chk("reset_busAddress", oBusAddress, 32'd0);
        chk("reset_rData", oRData, 32'd0);
        iReset = 1'b0;
        @(posedge iClock); #2;

        // Uncontended zero-wait read
        xfer(0, 32'h0000_1004, 1'b0, 32'd0, 1, 32'hDEAD_BEEF, n, rd, er);
        chk("t1_access_cycles", n, 1);
        chk("t1_rdata", rd, 32'hDEAD_BEEF);
        chk("t1_error", er, 1'b0);
        repeat (2) @(posedge iClock); #2;

        // Both requesters held continuously with zero wait states
        exp_order = 10'b10_0001_0000;
        got_order = '0;
        iReq0 = 1; iAddr0 = 32'h0000_0100; iWrite0 = 0; iWData0 = 32'h1111_1111;
        iReq1 = 1; iAddr1 = 32'h0000_0200; iWrite1 = 0; iWData1 = 32'h2222_2222;
        iBusReady = 1; iBusRData = 32'h7777_0000;
        n = 0;
        for (int c = 0; c < 100 && n < 10; c++) begin
            @(posedge iClock); #2;
            if (oBusAccess) begin
                got_order[n] = oGrant1;
                chk("ctn_owner_addr", oBusAddress, oGrant1 ? 32'h0000_0200 : 32'h0000_0100);
                n++;
            end
        end
        chk("ctn_grant_count", n, 10);
        for (int i = 0; i < 10; i++) chk("ctn_grant_order", got_order[i], exp_order[i]);
        @(posedge iClock); #2;
        iReq0 = 0; iReq1 = 0; iBusReady = 0;
        repeat (2) @(posedge iClock); #2;

        // Wait-stated write from the DMA master
        xfer(1, 32'h0000_3000, 1'b1, 32'h1234_5678, 5, 32'hCAFE_F00D, n, rd, er);
        chk("t3_access_cycles", n, 5);
        chk("t3_rdata", rd, 32'd0);
        chk("t3_error", er, 1'b0);
        repeat (2) @(posedge iClock); #2;

        // Ready never arrives
        xfer(0, 32'h0000_0400, 1'b0, 32'd0, 0, 32'h55AA_55AA, n, rd, er);
        chk("t4_access_cycles", n, 256);
        chk("t4_rdata", rd, 32'd0);
        chk("t4_error", er, 1'b1);
        xfer(1, 32'h0000_0800, 1'b0, 32'd0, 2, 32'h0BAD_F00D, n, rd, er);
        chk("t4b_access_cycles", n, 2);
        chk("t4b_rdata", rd, 32'h0BAD_F00D);
        chk("t4b_error", er, 1'b0);
        repeat (2) @(posedge iClock); #2;

        // Reset in the third ACCESS cycle of a stalled read
        iReq0 = 1; iAddr0 = 32'h0000_4000; iWrite0 = 0; iWData0 = 32'd0; iBusReady = 0;
        n = 0;
        for (int c = 0; c < 20 && n < 3; c++) begin
            @(posedge iClock); #2;
            if (oGrant0) n++;
        end
        chk("t5_reached_access3", n, 3);
        iReset = 1; iReq0 = 0;
        @(posedge iClock); #2;
        chk("t5_busAccess", oBusAccess, 1'b0);
        chk("t5_grant0", oGrant0, 1'b0);
        chk("t5_done0", oDone0, 1'b0);
        chk("t5_busAddress", oBusAddress, 32'd0);
        chk("t5_rData", oRData, 32'd0);
        chk("t5_error", oError, 1'b0);
        iReset = 0;
        seen = 0;
        repeat (5) begin
            @(posedge iClock); #2;
            if (oDone0) seen = 1;
        end
        chk("t5_no_done", seen, 1'b0);
        xfer(0, 32'h0000_4000, 1'b0, 32'd0, 3, 32'h1357_9BDF, n, rd, er);
        chk("t5b_access_cycles", n, 3);
        chk("t5b_rdata", rd, 32'h1357_9BDF);
        repeat (2) @(posedge iClock); #2;

        // Ready lands exactly on the last timeout cycle
        xfer(0, 32'h0000_0C00, 1'b0, 32'd0, 256, 32'hA5A5_A5A5, n, rd, er);
        chk("t6_access_cycles", n, 256);
        chk("t6_rdata", rd, 32'hA5A5_A5A5);
        chk("t6_error", er, 1'b0);
        repeat (3) @(posedge iClock); #2;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
